// File: rtl/escaner_teclado_if.sv
// Keypad-side signal bundle for the matrix scanner.
// The scanner uses master; the keypad or bench side uses slave.
interface escaner_teclado_if;
  logic [3:0] i_Filas;
  logic [3:0] o_Columnas;
  logic [1:0] o_Sel;
  logic [3:0] o_Tecla;
  logic       o_Valida;
  logic       o_Presionada;

  modport master (
    input  i_Filas,
    output o_Columnas, o_Sel, o_Tecla, o_Valida, o_Presionada
  );

  modport slave (
    output i_Filas,
    input  o_Columnas, o_Sel, o_Tecla, o_Valida, o_Presionada
  );
endinterface

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: one-cold column ring, synchronized active-low rows,
// press/release debounce, and a single-cycle pulse when a new key is accepted.
module escaner_teclado #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  escaner_teclado_if.master   kp
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_N + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  function automatic logic [3:0] decode_col(input logic [1:0] sel);
    logic [3:0] col;
    case (sel)
      2'd0:    col = 4'b0111;
      2'd1:    col = 4'b1011;
      2'd2:    col = 4'b1101;
      2'd3:    col = 4'b1110;
      default: col = 4'b0111;
    endcase
    return col;
  endfunction

  // Lowest-index low row wins when several rows are pressed together.
  function automatic logic [1:0] low_row(input logic [3:0] filas);
    logic [1:0] idx;
    if (!filas[0]) begin
      idx = 2'd0;
    end else if (!filas[1]) begin
      idx = 2'd1;
    end else if (!filas[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]    sync1_r, filas_s;
  logic [DW-1:0] div_r;
  logic          tick;
  state_t        state_r, state_n;
  logic [1:0]    sel_r, sel_n;
  logic [3:0]    col_r;
  logic [3:0]    cand_r, cand_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [CW-1:0] rel_r, rel_n;
  logic [3:0]    tecla_r, tecla_n;
  logic          valida_r, valida_n;
  logic          pres_r, pres_n;
  logic          any_low;
  logic [1:0]    row_low;

  assign tick    = (div_r == DW'(SCAN_DIV - 1));
  assign any_low = (filas_s != 4'b1111);
  assign row_low = low_row(filas_s);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      sync1_r <= 4'b1111;
      filas_s <= 4'b1111;
    end else begin
      sync1_r <= kp.i_Filas;
      filas_s <= sync1_r;
    end
  end

  // Free-running scan divider.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      div_r <= '0;
    end else if (tick) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_r  <= SCAN;
      sel_r    <= 2'd0;
      col_r    <= 4'b0111;
      cand_r   <= 4'd0;
      cnt_r    <= '0;
      rel_r    <= '0;
      tecla_r  <= 4'd0;
      valida_r <= 1'b0;
      pres_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      sel_r    <= sel_n;
      col_r    <= decode_col(sel_n);
      cand_r   <= cand_n;
      cnt_r    <= cnt_n;
      rel_r    <= rel_n;
      tecla_r  <= tecla_n;
      valida_r <= valida_n;
      pres_r   <= pres_n;
    end
  end

  // Next-state logic: scan, debounce a candidate, then wait for a debounced release.
  always_comb begin
    state_n  = state_r;
    sel_n    = sel_r;
    cand_n   = cand_r;
    cnt_n    = cnt_r;
    rel_n    = rel_r;
    tecla_n  = tecla_r;
    valida_n = 1'b0;
    pres_n   = pres_r;
    case (state_r)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            cand_n = {sel_r, row_low};
            if (DEBOUNCE_N == 1) begin
              tecla_n  = {sel_r, row_low};
              valida_n = 1'b1;
              pres_n   = 1'b1;
              rel_n    = '0;
              cnt_n    = CW'(1);
              state_n  = HELD;
            end else begin
              cnt_n   = CW'(1);
              state_n = DEBOUNCE;
            end
          end else begin
            sel_n = sel_r + 2'd1;
          end
        end else begin
          state_n = SCAN;
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (any_low && (row_low == cand_r[1:0])) begin
            if (cnt_r == CW'(DEBOUNCE_N - 1)) begin
              cnt_n    = CW'(DEBOUNCE_N);
              tecla_n  = cand_r;
              valida_n = 1'b1;
              pres_n   = 1'b1;
              rel_n    = '0;
              state_n  = HELD;
            end else begin
              cnt_n = cnt_r + CW'(1);
            end
          end else begin
            cnt_n   = '0;
            sel_n   = sel_r + 2'd1;
            state_n = SCAN;
          end
        end else begin
          state_n = DEBOUNCE;
        end
      end
      HELD: begin
        if (tick) begin
          if (filas_s[tecla_r[1:0]]) begin
            if (rel_r == CW'(DEBOUNCE_N - 1)) begin
              rel_n   = '0;
              cnt_n   = '0;
              pres_n  = 1'b0;
              sel_n   = sel_r + 2'd1;
              state_n = SCAN;
            end else begin
              rel_n = rel_r + CW'(1);
            end
          end else begin
            rel_n = '0;
          end
        end else begin
          state_n = HELD;
        end
      end
      default: begin
        state_n = SCAN;
        cnt_n   = '0;
        rel_n   = '0;
        pres_n  = 1'b0;
      end
    endcase
  end

  assign kp.o_Columnas   = col_r;
  assign kp.o_Sel        = sel_r;
  assign kp.o_Tecla      = tecla_r;
  assign kp.o_Valida     = valida_r;
  assign kp.o_Presionada = pres_r;

endmodule

// File: tb/tb_escaner_teclado.sv
// Directed bench for escaner_teclado with SCAN_DIV=4, DEBOUNCE_N=3 and a one-key keypad model.
module tb_escaner_teclado;

  logic       clk;
  logic       rst;
  logic       press;
  logic [1:0] pcol;
  logic [3:0] pmask;
  int         n_vec;
  int         n_bad;
  int         edge_n;
  int         vcount;

  escaner_teclado_if kif();

  escaner_teclado #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .kp      (kif)
  );

  // Keypad: pressed rows pull low only while their column is the one being driven.
  assign kif.i_Filas = (press && (kif.o_Sel == pcol)) ? ~pmask : 4'hF;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kif.o_Valida === 1'b1) vcount <= vcount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst = 1'b1; press = 1'b0; pcol = 2'd0; pmask = 4'd0;
    n_vec = 0; n_bad = 0; edge_n = 0; vcount = 0;

    // Reset values appear without a clock edge.
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_cols",  kif.o_Columnas,   4'b0111);
    chk("rst_sel",   kif.o_Sel,        2'd0);
    chk("rst_tecla", kif.o_Tecla,      4'd0);
    chk("rst_val",   kif.o_Valida,     1'b0);
    chk("rst_pres",  kif.o_Presionada, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; edge_n = 0;

    // Idle scan ring, four clocks per column.
    step_to(3);  chk("ring_c0",   kif.o_Columnas, 4'b0111);
    step_to(4);  chk("ring_c1",   kif.o_Columnas, 4'b1011);
    step_to(7);  chk("ring_c1b",  kif.o_Columnas, 4'b1011);
    step_to(8);  chk("ring_c2",   kif.o_Columnas, 4'b1101);
    step_to(12); chk("ring_c3",   kif.o_Columnas, 4'b1110);
    step_to(16); chk("ring_wrap", kif.o_Columnas, 4'b0111);
    chk("ring_noval", vcount, 0);

    // Key col 2 row 1: detected at E28, accepted at E36.
    press = 1'b1; pcol = 2'd2; pmask = 4'b0010;
    step_to(35); chk("acc_pre_val", kif.o_Valida, 1'b0);
    chk("acc_pre_pres", kif.o_Presionada, 1'b0);
    step_to(36); chk("acc_val",   kif.o_Valida,     1'b1);
    chk("acc_tecla", kif.o_Tecla,      4'b1001);
    chk("acc_pres",  kif.o_Presionada, 1'b1);
    step_to(37); chk("acc_pulse", kif.o_Valida,     1'b0);
    step_to(45); chk("held_cols", kif.o_Columnas,   4'b1101);
    chk("held_sel", kif.o_Sel, 2'd2);

    // Release debounced over ticks E48, E52, E56.
    press = 1'b0;
    step_to(55); chk("rel_pre_pres", kif.o_Presionada, 1'b0 ^ 1'b1);
    step_to(56); chk("rel_pres", kif.o_Presionada, 1'b0);
    chk("rel_sel",  kif.o_Sel,      2'd3);
    chk("rel_cols", kif.o_Columnas, 4'b1110);
    chk("rel_vcnt", vcount, 1);

    // Bounce: detected at E72, row gone before E80, scan resumes at column 3.
    press = 1'b1; pcol = 2'd2; pmask = 4'b0010;
    step_to(76); chk("bnc_cols_a", kif.o_Columnas, 4'b1101);
    press = 1'b0;
    step_to(79); chk("bnc_cols_b", kif.o_Columnas, 4'b1101);
    step_to(80); chk("bnc_cols", kif.o_Columnas,   4'b1110);
    chk("bnc_tecla", kif.o_Tecla,      4'b1001);
    chk("bnc_pres",  kif.o_Presionada, 1'b0);
    chk("bnc_vcnt",  vcount, 1);

    // Rows 0 and 2 in column 0: row 0 wins, detected E88, accepted E96.
    press = 1'b1; pcol = 2'd0; pmask = 4'b0101;
    step_to(95); chk("two_pre_val",   kif.o_Valida, 1'b0);
    chk("two_pre_tecla", kif.o_Tecla, 4'b1001);
    step_to(96); chk("two_val", kif.o_Valida,     1'b1);
    chk("two_tecla", kif.o_Tecla,      4'b0000);
    chk("two_pres",  kif.o_Presionada, 1'b1);
    step_to(110); chk("two_hold_tecla", kif.o_Tecla, 4'b0000);
    chk("two_vcnt", vcount, 2);

    // Release (clears at E112, counts E116..E124), then key col 3 row 2.
    press = 1'b0;
    step_to(124); chk("rel2_pres", kif.o_Presionada, 1'b0);
    chk("rel2_sel", kif.o_Sel, 2'd1);
    press = 1'b1; pcol = 2'd3; pmask = 4'b0100;
    step_to(144); chk("k32_val", kif.o_Valida, 1'b1);
    chk("k32_tecla", kif.o_Tecla, 4'b1110);
    step_to(150); chk("k32_cols", kif.o_Columnas, 4'b1110);
    chk("k32_pres", kif.o_Presionada, 1'b1);

    // Asynchronous reset in HELD, mid clock phase.
    #2; rst = 1'b0; #1;
    chk("arst_cols",  kif.o_Columnas,   4'b0111);
    chk("arst_sel",   kif.o_Sel,        2'd0);
    chk("arst_tecla", kif.o_Tecla,      4'd0);
    chk("arst_val",   kif.o_Valida,     1'b0);
    chk("arst_pres",  kif.o_Presionada, 1'b0);
    press = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("arst_vcnt", vcount, 3);
    rst = 1'b1; edge_n = 0;

    // Scanning restarts at column 0.
    step_to(3); chk("restart_c0", kif.o_Sel, 2'd0);
    step_to(4); chk("restart_c1", kif.o_Sel, 2'd1);
    chk("end_vcnt", vcount, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 SCAN_DIV, 50000, clock cycles each column is driven before its rows are sampled; legal range 2 or more.
REQ-002 DEBOUNCE_N, 4, consecutive matching samples needed to accept a press or a release; legal range 1 to 15.
REQ-003 i_Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-low reset.
REQ-005 i_Filas  input  4  keypad row lines; active-low, externally pulled up, asynchronous to i_Clk.
REQ-006 o_Columnas  output  4  keypad column drive; one-cold ring, same sequence as the display anode ring.
REQ-007 o_Sel  output  2  index of the currently driven column.
REQ-008 o_Tecla  output  4  last accepted key code, {column index, row index}.
REQ-009 o_Valida  output  1  single-cycle pulse on the cycle o_Tecla takes a newly accepted code.
REQ-010 o_Presionada  output  1  level, high while the accepted key is considered held.

Function
REQ-011 i_Filas shall pass through a 2-flop synchronizer; all decisions use the synchronized value (filas_s).
REQ-012 A free-running divider shall count 0..SCAN_DIV-1 and wrap; "tick" is the cycle where the count equals SCAN_DIV-1; the divider never stops or restarts outside reset.
REQ-013 The column mapping shall be o_Sel 00->o_Columnas 0111, 01->1011, 10->1101, 11->1110; o_Columnas is always the decode of o_Sel.
REQ-014 FSM states shall be SCAN, DEBOUNCE, HELD; only the state transitions below are legal.
REQ-015 SCAN, tick, filas_s==1111: o_Sel increments modulo 4 (11 wraps to 00).
REQ-016 SCAN, tick, any filas_s bit low: candidate = {o_Sel, lowest-index low row}; count=1; go to DEBOUNCE; o_Sel is held; if DEBOUNCE_N==1, accept immediately per REQ-018.
REQ-017 DEBOUNCE, tick: if the same candidate is present (lowest low row unchanged), count increments; otherwise go to SCAN and o_Sel advances by one on that tick.
REQ-018 Acceptance, when count reaches DEBOUNCE_N: o_Tecla=candidate, o_Valida=1 for exactly that one cycle, o_Presionada=1, release count cleared, go to HELD.
REQ-019 HELD: o_Sel frozen. Tick with the accepted row bit high increments the release count. Tick with that row bit low clears the release count.
REQ-020 HELD, release count reaches DEBOUNCE_N: o_Presionada=0, o_Sel advances by one, go to SCAN; no o_Valida at release.
REQ-021 Key selection rules:
- Multiple rows low in one column: lowest row index wins.
- Keys in several columns: the first column reached in scan order wins.
- Other keys pressed while in HELD are ignored.
REQ-022 o_Tecla shall hold its value until the next acceptance; it is not cleared on release.
REQ-023 Counters shall be wide enough for DEBOUNCE_N with no overflow; they saturate only at the acceptance or release threshold.

Reset
REQ-024 While i_Reset=0, outputs shall be forced asynchronously to o_Columnas=0111, o_Sel=00, o_Tecla=0000, o_Valida=0, o_Presionada=0.
REQ-025 While i_Reset=0, internal state shall be FSM=SCAN, divider=0, all counters=0, synchronizer flops=1111.
REQ-026 Reset asserted in any state, including DEBOUNCE or HELD, shall abandon the operation with no o_Valida pulse.
REQ-027 After reset release, scanning shall restart at column 00.

Verification (SCAN_DIV=4, DEBOUNCE_N=3)
REQ-028 Reset low then released, i_Filas=1111 -> o_Columnas cycles 0111,1011,1101,1110,0111, each value held 4 clocks; o_Valida stays 0.
REQ-029 i_Filas[1]=0 whenever o_Columnas==1101, held stable -> o_Columnas freezes at 1101; one o_Valida pulse with o_Tecla=1001 on the 3rd tick after detection; o_Presionada=1.
REQ-030 Same key but row released after 2 ticks (bounce) -> no o_Valida; o_Tecla unchanged; scanning resumes at 1110 on the failing tick.
REQ-031 From HELD, rows 1111 for 3 consecutive ticks -> o_Presionada falls on the 3rd tick; o_Sel goes to 11; only one o_Valida pulse for the whole press.
REQ-032 Rows 0 and 2 low in column 00, stable -> o_Tecla=0000 after acceptance; the second key is never reported.
REQ-033 i_Reset=0 during HELD -> outputs reach REQ-024 values without waiting for a clock edge; no o_Valida pulse.
